// File: rtl/gctr_counter_block_gen_pkg.sv
// Shared GCM constants, FSM state type and the inc32 counter helper.
package gctr_counter_block_gen_pkg;

  localparam int unsigned GCM_NB_BLOCK = 128;
  localparam int unsigned GCM_NB_IV    = 96;
  localparam int unsigned GCM_NB_CTR   = 32;

  // Counter field of the pre-counter block J0 = IV || 0x00000001.
  localparam logic [GCM_NB_CTR-1:0] GCM_J0_CTR = 32'h0000_0001;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } gctr_state_t;

  // Increment of the low 32-bit counter field, modulo 2^32.
  function automatic logic [GCM_NB_CTR-1:0] inc32(input logic [GCM_NB_CTR-1:0] ctr);
    return ctr + GCM_NB_CTR'(1);
  endfunction

endpackage

// File: rtl/gctr_counter_block_gen_dly.sv
// Fixed-latency delay line with valid; each data stage only loads when its
// incoming valid is set, so the output holds its last value while idle.
module gctr_delay_valid #(
  parameter int unsigned NB_DATA = 8,
  parameter int unsigned DELAY   = 1
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic [NB_DATA-1:0] i_data,
  output logic               o_valid,
  output logic [NB_DATA-1:0] o_data
);

  for (genvar g = 0; g < DELAY; g++) begin : g_stage
    logic               r_valid;
    logic [NB_DATA-1:0] r_data;
    logic               w_vin;
    logic [NB_DATA-1:0] w_din;

    if (g == 0) begin : g_first
      assign w_vin = i_valid;
      assign w_din = i_data;
    end else begin : g_next
      assign w_vin = g_stage[g-1].r_valid;
      assign w_din = g_stage[g-1].r_data;
    end

    // One pipeline stage: valid always shifts, data loads only with valid.
    always_ff @(posedge i_clock) begin
      if (i_reset) begin
        r_valid <= 1'b0;
        r_data  <= '0;
      end else begin
        r_valid <= w_vin;
        if (w_vin) begin
          r_data <= w_din;
        end
      end
    end
  end

  assign o_valid = g_stage[DELAY-1].r_valid;
  assign o_data  = g_stage[DELAY-1].r_data;

endmodule

// File: rtl/gctr_counter_block_gen_inc32.sv
// Combinational 32-bit modular incrementer; o_carry flags the 0xFFFFFFFF -> 0 wrap.
module gctr_inc32 (
  input  logic [31:0] i_ctr,
  output logic [31:0] o_ctr,
  output logic        o_carry
);
  import gctr_counter_block_gen_pkg::*;

  // Next counter value and wrap detect.
  always_comb begin
    o_ctr   = inc32(i_ctr);
    o_carry = &i_ctr;
  end

endmodule

// File: rtl/gctr_counter_block_gen.sv
// GCM counter-block generator: emits J0 once per message, then one inc32
// counter block per data beat, with the beat carried alongside.
module gctr_counter_block_gen #(
  parameter int unsigned NB_BYTE = 8,
  parameter int unsigned N_BYTES = 16,
  parameter int unsigned NB_IV   = 96,
  parameter int unsigned NB_CTR  = 32
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic [NB_IV-1:0]           i_iv,
  input  logic                       i_iv_valid,
  input  logic [N_BYTES*NB_BYTE-1:0] i_data,
  input  logic                       i_valid,
  input  logic                       i_eom,
  output logic [N_BYTES*NB_BYTE-1:0] o_state,
  output logic [N_BYTES*NB_BYTE-1:0] o_data,
  output logic                       o_valid,
  output logic                       o_j0,
  output logic                       o_eom,
  output logic                       o_busy,
  output logic                       o_drop,
  output logic                       o_abort,
  output logic                       o_ctr_wrap
);
  import gctr_counter_block_gen_pkg::*;

  localparam int unsigned NB_BLOCK = N_BYTES * NB_BYTE;

  gctr_state_t         r_state;
  gctr_state_t         w_state_next;
  logic [NB_IV-1:0]    r_iv;
  logic [NB_CTR-1:0]   r_ctr;
  logic [NB_CTR-1:0]   w_ctr_inc;
  logic                w_carry;
  logic                w_ld_iv;
  logic                w_beat;
  logic                w_drop;
  logic                w_abort;
  logic                w_out_valid;
  logic [NB_BLOCK-1:0] w_out_state;
  logic [NB_BLOCK-1:0] w_out_data;
  logic                r_j0;
  logic                r_eom;
  logic                r_busy;
  logic                r_drop;
  logic                r_abort;
  logic                r_ctr_wrap;

  // State register.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: a new IV always (re)starts a message; eom beat ends it.
  always_comb begin
    w_state_next = r_state;
    if (i_iv_valid) begin
      w_state_next = ST_RUN;
    end else if (w_beat && i_eom) begin
      w_state_next = ST_IDLE;
    end
  end

  // Per-cycle actions; i_iv_valid wins over a coincident data beat.
  always_comb begin
    w_ld_iv = i_iv_valid;
    w_beat  = i_valid && !i_iv_valid && (r_state == ST_RUN);
    w_drop  = i_valid && (i_iv_valid || (r_state == ST_IDLE));
    w_abort = i_iv_valid && (r_state == ST_RUN);
  end

  gctr_inc32 u_inc32 (
    .i_ctr   (r_ctr),
    .o_ctr   (w_ctr_inc),
    .o_carry (w_carry)
  );

  // IV and counter registers.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_iv  <= '0;
      r_ctr <= '0;
    end else if (w_ld_iv) begin
      r_iv  <= i_iv;
      r_ctr <= NB_CTR'(GCM_J0_CTR);
    end else if (w_beat) begin
      r_ctr <= w_ctr_inc;
    end
  end

  // Sticky wrap flag, rearmed by each new IV.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_ctr_wrap <= 1'b0;
    end else if (w_ld_iv) begin
      r_ctr_wrap <= 1'b0;
    end else if (w_beat && w_carry) begin
      r_ctr_wrap <= 1'b1;
    end
  end

  // Block/beat selection feeding the output register stage.
  always_comb begin
    w_out_valid = w_ld_iv || w_beat;
    w_out_state = {r_iv, w_ctr_inc};
    w_out_data  = i_data;
    if (w_ld_iv) begin
      w_out_state = {i_iv, NB_CTR'(GCM_J0_CTR)};
      w_out_data  = '0;
    end
  end

  gctr_delay_valid #(
    .NB_DATA (2 * NB_BLOCK),
    .DELAY   (1)
  ) u_out_dly (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_valid (w_out_valid),
    .i_data  ({w_out_state, w_out_data}),
    .o_valid (o_valid),
    .o_data  ({o_state, o_data})
  );

  // Sideband flags registered in step with the delay line.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_j0    <= 1'b0;
      r_eom   <= 1'b0;
      r_busy  <= 1'b0;
      r_drop  <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_j0    <= w_ld_iv;
      r_eom   <= w_beat && i_eom;
      r_busy  <= (w_state_next == ST_RUN);
      r_drop  <= w_drop;
      r_abort <= w_abort;
    end
  end

  assign o_j0       = r_j0;
  assign o_eom      = r_eom;
  assign o_busy     = r_busy;
  assign o_drop     = r_drop;
  assign o_abort    = r_abort;
  assign o_ctr_wrap = r_ctr_wrap;

endmodule

// File: tb/tb_gctr_counter_block_gen.sv
// Bench for gctr_counter_block_gen: message-level model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_gctr_counter_block_gen;

  logic         clk = 1'b0;
  logic         i_reset = 1'b1;
  logic [95:0]  i_iv = '0;
  logic         i_iv_valid = 1'b0;
  logic [127:0] i_data = '0;
  logic         i_valid = 1'b0;
  logic         i_eom = 1'b0;
  logic [127:0] o_state, o_data;
  logic         o_valid, o_j0, o_eom, o_busy, o_drop, o_abort, o_ctr_wrap;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  gctr_counter_block_gen #(
    .NB_BYTE (8),
    .N_BYTES (16),
    .NB_IV   (96),
    .NB_CTR  (32)
  ) dut (
    .i_clock    (clk),
    .i_reset    (i_reset),
    .i_iv       (i_iv),
    .i_iv_valid (i_iv_valid),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .i_eom      (i_eom),
    .o_state    (o_state),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_j0       (o_j0),
    .o_eom      (o_eom),
    .o_busy     (o_busy),
    .o_drop     (o_drop),
    .o_abort    (o_abort),
    .o_ctr_wrap (o_ctr_wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- message-level model ----------------
  bit           m_in_msg = 0;
  logic [95:0]  m_iv = '0;
  longint       m_ctr = 0;
  bit           m_wrap = 0;
  logic [127:0] e_state = '0, e_data = '0;
  bit           e_valid = 0, e_j0 = 0, e_eom = 0, e_busy = 0, e_drop = 0, e_abort = 0;

  always @(posedge clk) begin
    if (i_reset) begin
      m_in_msg = 0; m_iv = '0; m_ctr = 0; m_wrap = 0;
      e_state = '0; e_data = '0;
      e_valid = 0; e_j0 = 0; e_eom = 0; e_drop = 0; e_abort = 0;
    end else begin
      e_valid = 0; e_j0 = 0; e_eom = 0; e_drop = 0; e_abort = 0;
      if (i_iv_valid) begin
        e_abort  = m_in_msg;
        e_drop   = i_valid;
        m_iv     = i_iv;
        m_ctr    = 1;
        m_wrap   = 0;
        m_in_msg = 1;
        e_valid  = 1; e_j0 = 1;
        e_state  = {m_iv, 32'h0000_0001};
        e_data   = '0;
      end else if (i_valid) begin
        if (m_in_msg) begin
          m_ctr = (m_ctr + 1) % 64'd4294967296;
          if (m_ctr == 0) m_wrap = 1;
          e_valid = 1;
          e_state = {m_iv, m_ctr[31:0]};
          e_data  = i_data;
          e_eom   = i_eom;
          if (i_eom) m_in_msg = 0;
        end else begin
          e_drop = 1;
        end
      end
    end
    e_busy = m_in_msg;
  end

  // Single compare point, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid", {127'd0, o_valid}, {127'd0, e_valid});
      chk("j0",    {127'd0, o_j0},    {127'd0, e_j0});
      chk("eom",   {127'd0, o_eom},   {127'd0, e_eom});
      chk("busy",  {127'd0, o_busy},  {127'd0, e_busy});
      chk("drop",  {127'd0, o_drop},  {127'd0, e_drop});
      chk("abort", {127'd0, o_abort}, {127'd0, e_abort});
      chk("wrap",  {127'd0, o_ctr_wrap}, {127'd0, m_wrap});
      chk("state", o_state, e_state);
      chk("data",  o_data,  e_data);
    end
  end

  // Drive one cycle of inputs at the falling edge; return just after the rising edge.
  task automatic drive(input logic rst, input logic ivv, input logic [95:0] iv,
                       input logic v, input logic [127:0] d, input logic e);
    @(negedge clk);
    i_reset = rst; i_iv_valid = ivv; i_iv = iv; i_valid = v; i_data = d; i_eom = e;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  localparam logic [95:0] IV1 = 96'hCAFEBABEFACEDBADDECAF888;
  localparam logic [95:0] IVA = 96'h0123456789ABCDEF00112233;
  localparam logic [95:0] IVB = 96'hFFEEDDCCBBAA998877665544;
  localparam logic [95:0] IVC = 96'h5A5A5A5AA5A5A5A5C3C3C3C3;
  localparam logic [127:0] D1 = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] D2 = 128'hDEADBEEF0000111122223333FEEDFACE;
  localparam logic [127:0] D3 = 128'h0F0E0D0C0B0A09080706050403020100;

  initial begin
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    chk_en = 1'b1;
    chk("rst_valid", {127'd0, o_valid}, 128'd0);
    chk("rst_state", o_state, 128'd0);
    chk("rst_busy",  {127'd0, o_busy}, 128'd0);

    // 1. Basic message
    drive(1'b0, 1'b1, IV1, 1'b0, '0, 1'b0);
    chk("t1_j0",    {127'd0, o_j0}, 128'd1);
    chk("t1_state", o_state, 128'hCAFEBABEFACEDBADDECAF888_00000001);
    chk("t1_data",  o_data, 128'd0);
    idle();
    drive(1'b0, 1'b0, '0, 1'b1, D1, 1'b0);
    chk("t1_b1",    o_state, 128'hCAFEBABEFACEDBADDECAF888_00000002);
    chk("t1_d1",    o_data, D1);
    drive(1'b0, 1'b0, '0, 1'b1, D2, 1'b0);
    chk("t1_b2",    o_state, 128'hCAFEBABEFACEDBADDECAF888_00000003);
    drive(1'b0, 1'b0, '0, 1'b1, D3, 1'b1);
    chk("t1_b3",    o_state, 128'hCAFEBABEFACEDBADDECAF888_00000004);
    chk("t1_eom",   {127'd0, o_eom}, 128'd1);
    chk("t1_busy",  {127'd0, o_busy}, 128'd0);
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);   // eom without valid: ignored
    chk("t1_hold",  o_state, 128'hCAFEBABEFACEDBADDECAF888_00000004);
    chk("t1_idle_v", {127'd0, o_valid}, 128'd0);

    // 2. Idle drop
    drive(1'b0, 1'b0, '0, 1'b1, D1, 1'b0);
    chk("t2_drop",  {127'd0, o_drop}, 128'd1);
    chk("t2_valid", {127'd0, o_valid}, 128'd0);
    idle();

    // 3. Abort
    drive(1'b0, 1'b1, IVA, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b1, D1, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b1, D2, 1'b0);
    drive(1'b0, 1'b1, IVB, 1'b0, '0, 1'b0);
    chk("t3_abort", {127'd0, o_abort}, 128'd1);
    chk("t3_j0",    o_state, 128'hFFEEDDCCBBAA998877665544_00000001);
    drive(1'b0, 1'b0, '0, 1'b1, D3, 1'b1);
    chk("t3_b1",    o_state, 128'hFFEEDDCCBBAA998877665544_00000002);
    chk("t3_noab",  {127'd0, o_abort}, 128'd0);

    // 4. Collision, from IDLE then from RUN
    drive(1'b0, 1'b1, IVA, 1'b1, D1, 1'b0);
    chk("t4_drop",  {127'd0, o_drop}, 128'd1);
    chk("t4_abort0", {127'd0, o_abort}, 128'd0);
    chk("t4_data",  o_data, 128'd0);
    drive(1'b0, 1'b1, IVC, 1'b1, D2, 1'b0);
    chk("t4_abort1", {127'd0, o_abort}, 128'd1);
    chk("t4_j0",    o_state, 128'h5A5A5A5AA5A5A5A5C3C3C3C3_00000001);

    // 5. Counter wrap: place the counter just below the wrap point
    force dut.r_ctr = 32'hFFFF_FFFE;
    m_ctr = 64'hFFFF_FFFE;
    #1 release dut.r_ctr;
    drive(1'b0, 1'b0, '0, 1'b1, D1, 1'b0);
    chk("t5_ff",    o_state, 128'h5A5A5A5AA5A5A5A5C3C3C3C3_FFFFFFFF);
    chk("t5_nowrap", {127'd0, o_ctr_wrap}, 128'd0);
    drive(1'b0, 1'b0, '0, 1'b1, D2, 1'b0);
    chk("t5_zero",  o_state, 128'h5A5A5A5AA5A5A5A5C3C3C3C3_00000000);
    chk("t5_wrap",  {127'd0, o_ctr_wrap}, 128'd1);
    drive(1'b0, 1'b0, '0, 1'b1, D3, 1'b0);
    chk("t5_one",   o_state, 128'h5A5A5A5AA5A5A5A5C3C3C3C3_00000001);
    chk("t5_sticky", {127'd0, o_ctr_wrap}, 128'd1);
    drive(1'b0, 1'b1, IV1, 1'b0, '0, 1'b0);
    chk("t5_clear", {127'd0, o_ctr_wrap}, 128'd0);

    // 6. Reset mid-message
    drive(1'b0, 1'b0, '0, 1'b1, D1, 1'b0);
    drive(1'b1, 1'b0, '0, 1'b1, D2, 1'b0);
    chk("t6_valid", {127'd0, o_valid}, 128'd0);
    chk("t6_busy",  {127'd0, o_busy}, 128'd0);
    chk("t6_state", o_state, 128'd0);
    drive(1'b0, 1'b1, IVB, 1'b0, '0, 1'b0);
    chk("t6_j0",    o_state, 128'hFFEEDDCCBBAA998877665544_00000001);
    drive(1'b0, 1'b0, '0, 1'b1, D3, 1'b1);
    chk("t6_b1",    o_state, 128'hFFEEDDCCBBAA998877665544_00000002);
    idle();
    idle();

    @(posedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
